// File: rtl/echo_pkg.sv
// Shared types and constants for the echo parameter sequencer.
package echo_pkg;

  localparam int unsigned GAIN_WIDTH  = 6;
  localparam int unsigned DELAY_WIDTH = 12;
  localparam int unsigned RAMP_STEP   = 1;

  typedef logic [GAIN_WIDTH-1:0]  gain_t;
  typedef logic [DELAY_WIDTH-1:0] delay_t;

  localparam delay_t MAX_DELAY     = 12'd4000;
  localparam delay_t DEFAULT_DELAY = 12'd4000;
  localparam gain_t  DEFAULT_GAIN  = 6'd0;

  typedef enum logic [2:0] {
    StIdle,
    StSlew,
    StRampDown,
    StSwitch,
    StFlush,
    StRampUp
  } echo_state_e;

endpackage

// File: rtl/echo_gain_slew.sv
// One saturating step of the gain toward a target; never overshoots the target.
module echo_gain_slew
  import echo_pkg::*;
(
  input  logic [GAIN_WIDTH-1:0] cur_i,
  input  logic [GAIN_WIDTH-1:0] tgt_i,
  output logic [GAIN_WIDTH-1:0] nxt_o
);

  localparam gain_t Step = gain_t'(RAMP_STEP);

  gain_t diff;

  always_comb begin
    nxt_o = tgt_i;
    diff  = '0;
    if (tgt_i > cur_i) begin
      diff = tgt_i - cur_i;
      if (diff > Step) nxt_o = cur_i + Step;
    end else begin
      diff = cur_i - tgt_i;
      if (diff > Step) nxt_o = cur_i - Step;
    end
  end

endmodule

// File: rtl/echo_ctrl.sv
// Gain/delay parameter sequencer: slews gain per sample, mutes and flushes around delay changes.
// Define ECHO_CTRL_RETARGET_EN to accept new requests while slewing or ramping up.
module echo_ctrl
  import echo_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sample_tick,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [GAIN_WIDTH-1:0]  cfg_gain,
  input  logic [DELAY_WIDTH-1:0] cfg_delay,
  output logic [GAIN_WIDTH-1:0]  gain_out,
  output logic [DELAY_WIDTH-1:0] delay_out,
  output logic                   busy
);

  echo_state_e state_q;
  gain_t       gain_q, tgt_gain_q, slew_tgt, slew_nxt;
  delay_t      delay_q, tgt_delay_q, flush_cnt_q, req_delay;
  logic        accept;

  assign req_delay = (cfg_delay > MAX_DELAY) ? MAX_DELAY : cfg_delay;

  always_comb begin
`ifdef ECHO_CTRL_RETARGET_EN
    cfg_ready = (state_q == StIdle) || (state_q == StSlew) || (state_q == StRampUp);
`else
    cfg_ready = (state_q == StIdle);
`endif
  end

  assign busy      = (state_q != StIdle);
  assign accept    = cfg_valid && cfg_ready;
  assign gain_out  = gain_q;
  assign delay_out = delay_q;

  // Ramp-down shares the slew step, aimed at silence.
  assign slew_tgt = (state_q == StRampDown) ? '0 : tgt_gain_q;

  echo_gain_slew u_slew (
    .cur_i (gain_q),
    .tgt_i (slew_tgt),
    .nxt_o (slew_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      gain_q      <= DEFAULT_GAIN;
      delay_q     <= DEFAULT_DELAY;
      tgt_gain_q  <= DEFAULT_GAIN;
      tgt_delay_q <= DEFAULT_DELAY;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            tgt_gain_q  <= cfg_gain;
            tgt_delay_q <= req_delay;
            if (req_delay != delay_q) begin
              state_q <= (gain_q == '0) ? StSwitch : StRampDown;
            end else if (cfg_gain != gain_q) begin
              state_q <= StSlew;
            end
          end
        end
        StSlew, StRampUp: begin
`ifdef ECHO_CTRL_RETARGET_EN
          if (accept) begin
            tgt_gain_q  <= cfg_gain;
            tgt_delay_q <= req_delay;
            state_q     <= (req_delay == delay_q) ? StSlew : StRampDown;
          end else
`endif
          if (gain_q == tgt_gain_q) begin
            state_q <= StIdle;
          end else if (sample_tick) begin
            gain_q <= slew_nxt;
            if (slew_nxt == tgt_gain_q) state_q <= StIdle;
          end
        end
        StRampDown: begin
          if (gain_q == '0) begin
            state_q <= StSwitch;
          end else if (sample_tick) begin
            gain_q <= slew_nxt;
            if (slew_nxt == '0) state_q <= StSwitch;
          end
        end
        StSwitch: begin
          delay_q     <= tgt_delay_q;
          flush_cnt_q <= tgt_delay_q;
          state_q     <= StFlush;
        end
        StFlush: begin
          gain_q <= '0;
          if (flush_cnt_q == '0) begin
            state_q <= StRampUp;
          end else if (sample_tick) begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
            if (flush_cnt_q == delay_t'(1)) state_q <= StRampUp;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_ctrl.sv
// Directed self-checking bench for echo_ctrl.
module tb_echo_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [5:0]  cfg_gain;
  logic [11:0] cfg_delay;
  logic [5:0]  gain_out;
  logic [11:0] delay_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_rt;

  always #5 clk = ~clk;

  echo_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_gain    (cfg_gain),
    .cfg_delay   (cfg_delay),
    .gain_out    (gain_out),
    .delay_out   (delay_out),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic req(input logic [5:0] g, input logic [11:0] d);
    cfg_valid = 1'b1;
    cfg_gain  = g;
    cfg_delay = d;
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
`ifdef ECHO_CTRL_RETARGET_EN
    exp_rt = 2;
`else
    exp_rt = 4;
`endif
    reset_n     = 1'b0;
    sample_tick = 1'b0;
    cfg_valid   = 1'b0;
    cfg_gain    = '0;
    cfg_delay   = '0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();

    // Reset state
    chk("rst_gain", gain_out, 0);
    chk("rst_delay", delay_out, 4000);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);

    // Gain-only slew 0 -> 10
    req(6'd10, 12'd4000);
    chk("slew_busy0", busy, 1);
    chk("slew_ready0", cfg_ready, 0);
    chk("slew_gain0", gain_out, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("slew_up_gain", gain_out, i);
      chk("slew_up_busy", busy, (i < 10) ? 1 : 0);
    end
    chk("slew_up_delay", delay_out, 4000);
    tick();
    chk("idle_tick_gain", gain_out, 10);

    // Slew down to 3
    req(6'd3, 12'd4000);
    repeat (7) tick();
    chk("slew_dn_gain", gain_out, 3);
    chk("slew_dn_busy", busy, 0);

    // Delay change: gain 3 -> delay 8 -> gain 5
    req(6'd5, 12'd8);
    chk("dchg_busy", busy, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("rampdn_gain", gain_out, 3 - i);
    end
    chk("pre_switch_delay", delay_out, 4000);
    cyc();
    chk("switch_delay", delay_out, 8);
    chk("flush_ready", cfg_ready, 0);
    req(6'd20, 12'd100);
    chk("flush_ignore_delay", delay_out, 8);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("flush_gain", gain_out, 0);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("rampup_gain", gain_out, i);
    end
    chk("rampup_busy", busy, 0);
    chk("rampup_delay", delay_out, 8);

    // Clamp 4095 -> 4000, ramp up to 0
    req(6'd0, 12'd4095);
    repeat (5) tick();
    chk("clamp_rampdn_gain", gain_out, 0);
    cyc();
    chk("clamp_delay", delay_out, 4000);
    repeat (4000) tick();
    chk("clamp_flush_busy", busy, 1);
    cyc();
    chk("clamp_done_busy", busy, 0);
    chk("clamp_done_gain", gain_out, 0);

    // No-op request
    req(6'd0, 12'd4000);
    chk("noop_busy", busy, 0);
    chk("noop_ready", cfg_ready, 1);

    // Retarget during slew
    req(6'd4, 12'd4000);
    tick();
    chk("rt_gain1", gain_out, 1);
    req(6'd2, 12'd4000);
    repeat (3) tick();
    chk("rt_final_gain", gain_out, exp_rt);
    chk("rt_final_busy", busy, 0);

    // Reset mid-flush
    req(6'd6, 12'd20);
    for (int i = 0; i < exp_rt; i++) tick();
    chk("rst_rampdn_gain", gain_out, 0);
    cyc();
    chk("rst_switch_delay", delay_out, 20);
    repeat (3) tick();
    chk("rst_flush_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_gain", gain_out, 0);
    chk("async_rst_delay", delay_out, 4000);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", cfg_ready, 1);
    reset_n = 1'b1;
    repeat (30) tick();
    chk("post_rst_gain", gain_out, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_delay", delay_out, 4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/echo_ctrl.md
# echo_ctrl

Parameter sequencer for the echo datapath. It accepts gain/delay update requests over a valid/ready handshake and drives the live gain and delay-length controls. Gain changes are slewed once per audio sample so they do not click. A delay-length change is applied safely: mute ramp, switch, flush of the delay line, then ramp back up. It sits between the control/register interface and the echo gain/delay stages, clocked on the system clock `clk`.

## Interface
- `GAIN_WIDTH`, 6: width of gain codes (unsigned fraction code).
- `DELAY_WIDTH`, 12: width of delay length in samples.
- `MAX_DELAY`, 4000: largest delay applied; larger requests clamp to this value.
- `DEFAULT_DELAY`, 4000: delay_out reset value.
- `DEFAULT_GAIN`, 0: gain_out reset value.
- `RAMP_STEP`, 1: maximum gain change per sample tick.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `sample_tick` in 1: one-`clk` pulse per audio sample, synchronous to `clk`.
- `cfg_valid` in 1: request valid.
- `cfg_ready` out 1: controller can accept a request.
- `cfg_gain` in GAIN_WIDTH: target gain.
- `cfg_delay` in DELAY_WIDTH: target delay in samples.
- `gain_out` out GAIN_WIDTH: live gain to the gain stage, registered.
- `delay_out` out DELAY_WIDTH: live delay length to the delay stage, registered.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Transfer occurs when `cfg_valid && cfg_ready`; the controller latches `tgt_gain` and `tgt_delay`.
  - `tgt_delay` = min(`cfg_delay`, `MAX_DELAY`).
- States: IDLE, SLEW, RAMP_DOWN, SWITCH, FLUSH, RAMP_UP.
- IDLE, on accepted request:
  - delay equal and gain equal: stay in IDLE (no-op).
  - delay equal, gain different: go to SLEW.
  - delay different and `gain_out`==0: go to SWITCH.
  - delay different and `gain_out`!=0: go to RAMP_DOWN.
- SLEW / RAMP_UP: on each `sample_tick`, move `gain_out` toward `tgt_gain` by min(`RAMP_STEP`, |diff|).
  - On the edge where `gain_out` reaches the target, the state goes to IDLE.
- RAMP_DOWN: on each tick, `gain_out` -= min(`RAMP_STEP`, `gain_out`).
  - On the edge where it reaches 0, the state goes to SWITCH.
- SWITCH: lasts one cycle, independent of ticks. `delay_out` <= `tgt_delay`, `flush_cnt` <= `tgt_delay`, then the state goes to FLUSH.
- FLUSH: each tick decrements `flush_cnt`.
  - On the tick where `flush_cnt` goes 1→0, the state goes to RAMP_UP.
  - If `flush_cnt` is 0 on entry, the state goes to RAMP_UP on the next cycle.
  - `gain_out` is held at 0 throughout FLUSH.
- RAMP_UP with `tgt_gain`==0: go to IDLE on the next cycle.
- Arithmetic: unsigned, no wrap. The gain step is saturated against the target. `flush_cnt` is DELAY_WIDTH bits.
- `sample_tick` outside SLEW/RAMP_DOWN/FLUSH/RAMP_UP has no effect.

## Timing
- Reset values: `gain_out`=DEFAULT_GAIN, `delay_out`=DEFAULT_DELAY, `busy`=0, `cfg_ready`=1, state IDLE, `flush_cnt`=0.
- `cfg_ready` and `busy` are decoded from registered state only; there is no combinational path from `cfg_valid`.
- An accepted request changes state on the same edge. `busy` is high on the following cycle unless the request was a no-op.
- `gain_out` updates on the `clk` edge where `sample_tick` is sampled high: one cycle of latency.
- `cfg_valid` while `cfg_ready`=0: ignored, not queued. The requester holds the request.
- Latency for a delay change from gain G to target T, with step S and new delay D: ceil(G/S) ticks + 1 cycle + D ticks + ceil(T/S) ticks.
- `reset_n` low mid-sequence: all outputs return to reset values immediately and the pending target is discarded.

## Configuration
- `ECHO_CTRL_RETARGET_EN` defined:
  - `cfg_ready` is also high in SLEW and RAMP_UP.
  - A request with `tgt_delay`==`delay_out` replaces `tgt_gain` and continues from the current `gain_out`.
  - A request with a different delay goes to RAMP_DOWN.
- Not defined: `cfg_ready` is high only in IDLE.

## Structure
- Shared package `echo_pkg`: state enum, `DEFAULT_DELAY`/`MAX_DELAY`/`DEFAULT_GAIN` constants, the gain and delay width typedefs.
- One sub-module, `echo_gain_slew`: computes the next gain value one step toward a target, saturating. It is used by SLEW, RAMP_UP and RAMP_DOWN.

## Test plan
- After reset: `gain_out`=0, `delay_out`=4000, `cfg_ready`=1, `busy`=0, before any tick.
- Request gain=10, delay=4000, STEP=1: `gain_out` goes 1..10 over 10 ticks; `busy` falls on the edge of the 10th tick update; `delay_out` stays 4000.
- From gain 3, request gain=5, delay=8: 3 ticks ramp to 0, one SWITCH cycle sets `delay_out`=8, 8 ticks at gain 0, then 5 ticks to 5; total 16 ticks + 1 cycle.
- Request delay=4095: `delay_out`=4000 (clamped). Request with no gain/delay change: no `busy` pulse.
- `cfg_valid` asserted during FLUSH: `cfg_ready`=0 and no target change. Retarget in SLEW: ignored without the macro, retargeted with it.
- `reset_n` pulsed low in FLUSH: outputs are immediately 0/4000 and state is IDLE; no RAMP_UP follows.
